// File: rtl/instr_prefetch_pkg.sv
// Shared defaults, fetch FSM states and the FIFO entry layout for the
// instruction prefetch buffer.
package instr_prefetch_pkg;

   localparam int          DEPTH_DEF    = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Circular buffer of {pc, instr} entries; flush wins over push and pop.
module prefetch_fifo
   import instr_prefetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  fetch_entry_t             i_wdata,
   output fetch_entry_t             o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   assign w_pop  = i_pop & (r_count != '0);
   assign w_push = i_push & ((r_count != FULL_C) | w_pop);

   always_ff @(posedge clk) begin
      if (w_push && !i_flush)
         r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: single-outstanding fetch FSM feeding a small FIFO
// toward IF/ID, with redirect flush and discard of in-flight data.
module instr_prefetch
   import instr_prefetch_pkg::*;
#(
   parameter int          DEPTH    = DEPTH_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  w_fetch_pc_nxt;
   logic         r_req;
   logic [31:0]  r_addr;
   logic         w_push;
   logic         w_pop;
   logic [CW:0]  w_count_nxt;
   logic         w_room;
   logic [31:0]  w_redir_pc;
   fetch_entry_t w_wdata;
   fetch_entry_t w_head;

   assign w_pop       = out_valid & out_ready;
   assign w_push      = (r_state == WAIT) & imem_ack & ~redirect;
   assign w_count_nxt = {1'b0, fifo_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
   // Issuing only when a slot is free after this edge reserves room for the reply.
   assign w_room      = (w_count_nxt < DEPTH_C);
   assign w_redir_pc  = redirect_pc & ~32'h3;

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      case (r_state)
         IDLE: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = WAIT;
            end else if (w_room) begin
               w_state_nxt    = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = imem_ack ? WAIT : DISCARD;
            end else if (imem_ack) begin
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               w_state_nxt    = w_room ? WAIT : IDLE;
            end
         end
         DISCARD: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = imem_ack ? WAIT : DISCARD;
            end else if (imem_ack) begin
               w_state_nxt    = WAIT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // In DISCARD the bus still carries the abandoned request's address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_req      <= (w_state_nxt != IDLE);
         r_addr     <= (w_state_nxt == DISCARD) ? r_addr : w_fetch_pc_nxt;
      end
   end

   assign w_wdata.pc    = r_fetch_pc;
   assign w_wdata.instr = imem_rdata;

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_wdata (w_wdata),
      .o_head  (w_head),
      .o_count (fifo_count)
   );

   assign imem_req  = r_req;
   assign imem_addr = r_addr;
   assign out_valid = (fifo_count != '0);
   assign out_instr = out_valid ? w_head.instr : 32'h0;
   assign out_pc    = out_valid ? w_head.pc    : 32'h0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: streaming, backpressure, slow memory,
// redirect/discard, address wrap and reset abandonment.
module tb_instr_prefetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_ack = 1'b0;
   logic        out_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  fifo_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Memory returns a word derived from the requested address.
   assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

   instr_prefetch dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fifo_count  (fifo_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_instr"}, out_instr, pc ^ 32'hDEAD_BEEF);
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // reset state
      step; step;
      chk("rst_req",   32'(imem_req),   32'd0);
      chk("rst_addr",  imem_addr,       32'h0);
      chk("rst_valid", 32'(out_valid),  32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_instr", out_instr,       32'h0);
      chk("rst_pc",    out_pc,          32'h0);

      // zero-wait streaming, one instruction per cycle
      reset = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
      step;
      chk("t1_req",   32'(imem_req),   32'd1);
      chk("t1_addr",  imem_addr,       32'h0);
      chk("t1_valid", 32'(out_valid),  32'd0);
      chk("t1_count", 32'(fifo_count), 32'd0);
      for (int n = 0; n < 6; n++) begin
         step;
         chk_head("t1_stream", 32'(4 * n));
         chk("t1_scount", 32'(fifo_count), 32'd1);
      end

      // reset mid-request abandons it
      reset = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
      #1;
      chk("t2_rst_req",   32'(imem_req),   32'd0);
      chk("t2_rst_count", 32'(fifo_count), 32'd0);
      step;
      reset = 1'b1; imem_ack = 1'b1;

      // backpressure: fill to DEPTH, request drops, head holds
      step;
      chk("t2_count0", 32'(fifo_count), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step;
         chk("t2_fill", 32'(fifo_count), 32'(k));
      end
      chk("t2_req_drop", 32'(imem_req), 32'd0);
      chk_head("t2_hold", 32'h0);
      step;
      chk("t2_req_idle",  32'(imem_req),   32'd0);
      chk("t2_count_sat", 32'(fifo_count), 32'd4);
      chk_head("t2_hold2", 32'h0);
      out_ready = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         step;
         chk_head("t2_resume", 32'(4 * n));
         chk("t2_rcount", 32'(fifo_count), 32'd3);
      end

      // 3-cycle memory latency
      reset = 1'b0; imem_ack = 1'b0;
      step;
      reset = 1'b1;
      step;
      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < 3; w++) begin
            step;
            chk("t3_addr_stable", imem_addr,      32'(4 * i));
            chk("t3_req",         32'(imem_req),  32'd1);
            chk("t3_novalid",     32'(out_valid), 32'd0);
         end
         imem_ack = 1'b1;
         step;
         imem_ack = 1'b0;
         chk_head("t3_slow", 32'(4 * i));
         chk("t3_next_addr", imem_addr,       32'(4 * (i + 1)));
         chk("t3_count",     32'(fifo_count), 32'd1);
      end

      // redirect with request outstanding -> discard late data
      out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      step;
      redirect = 1'b0;
      chk("t4_flush_count", 32'(fifo_count), 32'd0);
      chk("t4_flush_valid", 32'(out_valid),  32'd0);
      chk("t4_req",         32'(imem_req),   32'd1);
      chk("t4_addr_hold",   imem_addr,       32'hC);
      step;
      chk("t4_addr_hold2",  imem_addr,       32'hC);
      imem_ack = 1'b1;
      step;
      chk("t4_dropped",     32'(out_valid),  32'd0);
      chk("t4_count",       32'(fifo_count), 32'd0);
      chk("t4_new_addr",    imem_addr,       32'h100);
      out_ready = 1'b1;
      step;
      chk_head("t4_first", 32'h100);
      chk("t4_addr104", imem_addr, 32'h104);
      step;
      chk_head("t4_second", 32'h104);

      // redirect + push + pop on one edge, misaligned target, wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      step;
      redirect = 1'b0;
      chk("t5_count", 32'(fifo_count), 32'd0);
      chk("t5_valid", 32'(out_valid),  32'd0);
      chk("t5_pc",    out_pc,          32'h0);
      chk("t5_addr",  imem_addr,       32'hFFFF_FFFC);
      step;
      chk_head("t5_top", 32'hFFFF_FFFC);
      chk("t5_wrap_addr", imem_addr, 32'h0);
      step;
      chk_head("t5_wrapped", 32'h0);
      chk("t5_addr4", imem_addr, 32'h4);

      // repeated redirect while discarding
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
      step;
      chk("t6_addr_hold", imem_addr,       32'h4);
      chk("t6_count",     32'(fifo_count), 32'd0);
      redirect_pc = 32'h300;
      step;
      redirect = 1'b0;
      chk("t6_addr_hold2", imem_addr,     32'h4);
      chk("t6_req",        32'(imem_req), 32'd1);
      imem_ack = 1'b1;
      step;
      chk("t6_addr300", imem_addr,      32'h300);
      chk("t6_valid",   32'(out_valid), 32'd0);
      step;
      chk_head("t6_first", 32'h300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
